// File: rtl/cpu_pkg.sv
// Shared core parameters and occupancy encodings for the pipeline-stage registers.
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_entry_reg.sv
// One payload+valid register: load sets valid and captures payload, clear drops valid only.
// Clear has priority over load; payload is left untouched when cleared.
module pipe_entry_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         vld,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (clr) begin
      vld <= 1'b0;
    end else if (ld) begin
      vld <= 1'b1;
      q   <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register carrying PC/INST/rd/rd-value, optional 2-entry skid buffer.
// Latency 1 cycle; SKID=1 gives registered A_READY at full throughput, SKID=0 a combinational A_READY.
module pipe_stage_skid
  import cpu_pkg::*;
#(
  parameter int XLEN = cpu_pkg::XLEN_DEF,
  parameter int REGW = cpu_pkg::REGW_DEF,
  parameter int SKID = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            FLUSH,
  input  logic            A_VALID,
  output logic            A_READY,
  input  logic [XLEN-1:0] A_PC,
  input  logic [XLEN-1:0] A_INST,
  input  logic [REGW-1:0] A_REG_D,
  input  logic [XLEN-1:0] A_REG_D_V,
  output logic            M_VALID,
  input  logic            M_READY,
  output logic [XLEN-1:0] M_PC,
  output logic [XLEN-1:0] M_INST,
  output logic [REGW-1:0] M_REG_D,
  output logic [XLEN-1:0] M_REG_D_V,
  output logic [1:0]      OCC
);

  localparam int EW = 3 * XLEN + REGW;

  logic [EW-1:0] a_dat;
  logic [EW-1:0] head_d;
  logic [EW-1:0] head_dat;
  logic          head_vld;
  logic          head_ld;
  logic          head_clr;
  logic          accept;
  logic          drain;

  assign a_dat   = {A_PC, A_INST, A_REG_D, A_REG_D_V};
  assign accept  = A_VALID & A_READY & ~FLUSH;
  assign drain   = head_vld & M_READY;
  assign M_VALID = head_vld;
  assign {M_PC, M_INST, M_REG_D, M_REG_D_V} = head_dat;

  pipe_entry_reg #(.W(EW)) u_head (
    .clk   (CLK),
    .rst_n (RST),
    .ld    (head_ld),
    .clr   (head_clr),
    .d     (head_d),
    .vld   (head_vld),
    .q     (head_dat)
  );

  if (SKID != 0) begin : g_skid
    logic [EW-1:0] skid_dat;
    logic          skid_vld;
    logic          skid_ld;
    logic          skid_clr;
    logic          head_from_skid;
    logic          a_ready_q;
    occ_e          occ;
    occ_e          occ_nxt;

    pipe_entry_reg #(.W(EW)) u_skid (
      .clk   (CLK),
      .rst_n (RST),
      .ld    (skid_ld),
      .clr   (skid_clr),
      .d     (a_dat),
      .vld   (skid_vld),
      .q     (skid_dat)
    );

    // The two valid flops are the state register; the skid only fills behind a valid head.
    assign occ = skid_vld ? OCC_TWO : (head_vld ? OCC_ONE : OCC_EMPTY);

    always_comb begin
      occ_nxt        = occ;
      head_ld        = 1'b0;
      head_clr       = 1'b0;
      skid_ld        = 1'b0;
      skid_clr       = 1'b0;
      head_from_skid = 1'b0;
      if (FLUSH) begin
        occ_nxt  = OCC_EMPTY;
        head_clr = 1'b1;
        skid_clr = 1'b1;
      end else begin
        case (occ)
          OCC_EMPTY: begin
            if (accept) begin
              head_ld = 1'b1;
              occ_nxt = OCC_ONE;
            end
          end
          OCC_ONE: begin
            if (accept && drain) begin
              head_ld = 1'b1;
            end else if (accept) begin
              skid_ld = 1'b1;
              occ_nxt = OCC_TWO;
            end else if (drain) begin
              head_clr = 1'b1;
              occ_nxt  = OCC_EMPTY;
            end
          end
          OCC_TWO: begin
            if (drain) begin
              head_ld        = 1'b1;
              head_from_skid = 1'b1;
              skid_clr       = 1'b1;
              occ_nxt        = OCC_ONE;
            end
          end
          default: begin
            occ_nxt  = OCC_EMPTY;
            head_clr = 1'b1;
            skid_clr = 1'b1;
          end
        endcase
      end
    end

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        a_ready_q <= 1'b1;
      end else begin
        a_ready_q <= (occ_nxt != OCC_TWO);
      end
    end

    assign head_d  = head_from_skid ? skid_dat : a_dat;
    assign A_READY = a_ready_q;
    assign OCC     = occ;
  end else begin : g_noskid
    always_comb begin
      head_ld  = 1'b0;
      head_clr = 1'b0;
      if (FLUSH) begin
        head_clr = 1'b1;
      end else if (accept) begin
        head_ld = 1'b1;
      end else if (drain) begin
        head_clr = 1'b1;
      end
    end

    assign head_d  = a_dat;
    assign A_READY = ~head_vld | M_READY;
    assign OCC     = head_vld ? OCC_ONE : OCC_EMPTY;
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized checks of pipe_stage_skid, one instance per SKID build.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst_n;

  logic        a_flush, a_valid, a_ready, a_mvalid, a_mready;
  logic [31:0] a_pc, a_inst, a_rdv, a_mpc, a_minst, a_mrdv;
  logic [4:0]  a_rd, a_mrd;
  logic [1:0]  a_occ;

  logic        b_flush, b_valid, b_ready, b_mvalid, b_mready;
  logic [31:0] b_pc, b_inst, b_rdv, b_mpc, b_minst, b_mrdv;
  logic [4:0]  b_rd, b_mrd;
  logic [1:0]  b_occ;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.XLEN(32), .REGW(5), .SKID(1)) u_skid1 (
    .CLK(clk), .RST(rst_n), .FLUSH(a_flush),
    .A_VALID(a_valid), .A_READY(a_ready), .A_PC(a_pc), .A_INST(a_inst),
    .A_REG_D(a_rd), .A_REG_D_V(a_rdv),
    .M_VALID(a_mvalid), .M_READY(a_mready), .M_PC(a_mpc), .M_INST(a_minst),
    .M_REG_D(a_mrd), .M_REG_D_V(a_mrdv), .OCC(a_occ)
  );

  pipe_stage_skid #(.XLEN(32), .REGW(5), .SKID(0)) u_skid0 (
    .CLK(clk), .RST(rst_n), .FLUSH(b_flush),
    .A_VALID(b_valid), .A_READY(b_ready), .A_PC(b_pc), .A_INST(b_inst),
    .A_REG_D(b_rd), .A_REG_D_V(b_rdv),
    .M_VALID(b_mvalid), .M_READY(b_mready), .M_PC(b_mpc), .M_INST(b_minst),
    .M_REG_D(b_mrd), .M_REG_D_V(b_mrdv), .OCC(b_occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc);
    a_valid = v;
    a_pc    = pc;
    a_inst  = inst_of(pc);
    a_rd    = pc[6:2];
    a_rdv   = ~pc;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] pc);
    b_valid = v;
    b_pc    = pc;
    b_inst  = inst_of(pc);
    b_rd    = pc[6:2];
    b_rdv   = ~pc;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [31:0] pa, pb;
  logic        exp_rdy, acc, drn;

  initial begin
    rst_n = 1'b0;
    a_flush = 1'b0; a_mready = 1'b0; drive_a(1'b1, 32'h50);
    b_flush = 1'b0; b_mready = 1'b0; drive_b(1'b0, 32'h0);

    // Reset held three cycles with a valid offer pending
    repeat (3) cyc();
    chk("rst_mvalid", a_mvalid, 0);
    chk("rst_occ", a_occ, 0);
    chk("rst_aready", a_ready, 1);
    chk("rst_mpc", a_mpc, 0);
    chk("rst0_mvalid", b_mvalid, 0);
    chk("rst0_aready", b_ready, 1);
    rst_n = 1'b1;
    cyc();
    chk("first_mvalid", a_mvalid, 1);
    chk("first_mpc", a_mpc, 32'h50);
    chk("first_minst", a_minst, 32'hA5A5_0050);
    chk("first_occ", a_occ, 1);

    // Streaming at full rate
    a_mready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_a(1'b1, 32'h100 + 32'(4 * i));
      cyc();
      chk("stream_mpc", a_mpc, 32'h100 + 32'(4 * i));
      chk("stream_mvalid", a_mvalid, 1);
      chk("stream_aready", a_ready, 1);
      if (i == 0) begin
        chk("rd0_mrd", {27'd0, a_mrd}, 0);
        chk("rd0_mrdv", a_mrdv, ~32'h100);
      end
    end
    drive_a(1'b0, 32'h0);
    cyc();
    chk("drain_occ", a_occ, 0);
    chk("drain_mvalid", a_mvalid, 0);

    // Backpressure fills the skid entry
    a_mready = 1'b0;
    drive_a(1'b1, 32'h200);
    cyc();
    chk("bp1_occ", a_occ, 1);
    chk("bp1_aready", a_ready, 1);
    chk("bp1_mpc", a_mpc, 32'h200);
    drive_a(1'b1, 32'h204);
    cyc();
    chk("bp2_occ", a_occ, 2);
    chk("bp2_aready", a_ready, 0);
    chk("bp2_mpc", a_mpc, 32'h200);
    drive_a(1'b1, 32'h208);
    cyc();
    chk("bp3_occ", a_occ, 2);
    chk("bp3_mpc_stable", a_mpc, 32'h200);
    a_mready = 1'b1;
    cyc();
    chk("rel1_mpc", a_mpc, 32'h204);
    chk("rel1_occ", a_occ, 1);
    chk("rel1_aready", a_ready, 1);
    cyc();
    chk("rel2_mpc", a_mpc, 32'h208);
    chk("rel2_occ", a_occ, 1);

    // Flush from OCC=2 with an offer pending
    a_mready = 1'b0;
    drive_a(1'b1, 32'h20C);
    cyc();
    chk("pre_flush_occ", a_occ, 2);
    a_flush = 1'b1;
    a_mready = 1'b1;
    drive_a(1'b1, 32'h300);
    cyc();
    chk("flush_mvalid", a_mvalid, 0);
    chk("flush_occ", a_occ, 0);
    chk("flush_aready", a_ready, 1);
    drive_a(1'b1, 32'h304);
    cyc();
    chk("flush_drop_mvalid", a_mvalid, 0);
    a_flush = 1'b0;
    drive_a(1'b0, 32'h0);
    cyc();
    chk("post_flush_mvalid", a_mvalid, 0);

    // SKID=0: combinational ready follows M_READY
    drive_b(1'b1, 32'h400);
    cyc();
    chk("s0_mpc", b_mpc, 32'h400);
    chk("s0_aready_stall", b_ready, 0);
    b_mready = 1'b1;
    drive_b(1'b1, 32'h404);
    #1;
    chk("s0_aready_go", b_ready, 1);
    cyc();
    chk("s0_mpc2", b_mpc, 32'h404);
    chk("s0_occ", b_occ, 1);
    drive_b(1'b1, 32'h408);
    cyc();
    chk("s0_mpc3", b_mpc, 32'h408);
    drive_b(1'b0, 32'h0);
    cyc();
    chk("s0_empty_mvalid", b_mvalid, 0);
    chk("s0_empty_occ", b_occ, 0);

    // Random valid/ready/flush against a queue model for both builds
    pa = 32'h1000;
    pb = 32'h8000;
    for (int c = 0; c < 3000; c++) begin
      a_mready = ($urandom_range(0, 9) < 6);
      a_flush  = ($urandom_range(0, 39) == 0);
      drive_a($urandom_range(0, 9) < 7, pa);
      b_mready = ($urandom_range(0, 9) < 6);
      b_flush  = ($urandom_range(0, 39) == 0);
      drive_b($urandom_range(0, 9) < 7, pb);
      #1;

      exp_rdy = (qa.size() != 2);
      chk("rnd1_aready", a_ready, exp_rdy);
      chk("rnd1_occ", a_occ, qa.size());
      chk("rnd1_mvalid", a_mvalid, qa.size() != 0);
      if (qa.size() != 0) begin
        chk("rnd1_mpc", a_mpc, qa[0]);
        chk("rnd1_minst", a_minst, inst_of(qa[0]));
      end
      acc = a_valid & exp_rdy & ~a_flush;
      drn = (qa.size() != 0) & a_mready;
      if (a_flush) qa.delete();
      else begin
        if (drn) void'(qa.pop_front());
        if (acc) begin qa.push_back(pa); pa += 4; end
      end

      exp_rdy = (qb.size() == 0) | b_mready;
      chk("rnd0_aready", b_ready, exp_rdy);
      chk("rnd0_occ", b_occ, qb.size());
      chk("rnd0_mvalid", b_mvalid, qb.size() != 0);
      if (qb.size() != 0) begin
        chk("rnd0_mpc", b_mpc, qb[0]);
        chk("rnd0_mrdv", b_mrdv, ~qb[0]);
      end
      acc = b_valid & exp_rdy & ~b_flush;
      drn = (qb.size() != 0) & b_mready;
      if (b_flush) qb.delete();
      else begin
        if (drn) void'(qb.pop_front());
        if (acc) begin qb.push_back(pb); pb += 4; end
      end

      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
